asmd_mult_arbiter: RTL

ASMD_MULT_ARBITER -- requirements
Module: asmd_mult_arbiter

---
 rtl/asmd_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/asmd_mult_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/asmd_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encodings,
// default parameter values and a small helper for index widths.
// No ports; imported by asmd_mult_arbiter and rr_arbiter.
package asmd_pkg;

    localparam int DEF_WORD_LENGTH  = 4;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_BUSY_TIMEOUT = 8;

    // Arbiter job states, one job in flight at a time
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Width of an index into n requesters; never narrower than one bit
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req        - per-requester request bits
//   last_grant - index of the most recently granted requester
//   grant      - one-hot winner: first set req bit strictly after last_grant,
//                wrapping from num_req-1 to 0; all zero when req is zero
module rr_arbiter
    import asmd_pkg::*;
#(
    parameter  int num_req = DEF_NUM_REQ,
    localparam int IDW     = idxWidth(num_req)
) (
    input  logic [num_req-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [num_req-1:0] grant
);

    logic [IDW-1:0] idx;
    logic           found;

    // Walk the requesters starting one past the last winner. The last
    // offset lands back on last_grant itself, so a lone requester is
    // re-granted without any extra cycle.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= num_req; off++) begin
            idx = IDW'((int'(last_grant) + off) % num_req);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/asmd_mult_arbiter.sv
// Shares one external multiplier among num_req requesters.
// Ports:
//   clk, reset            - clock and asynchronous active-low reset
//   req_valid/word0/word1 - per-requester request and flattened operands
//   req_grant             - one-hot pulse when a request is accepted
//   resp_valid/product/err- one-hot result pulse, product, timeout flag
//   busy                  - high whenever a job is in progress
//   mult_*                - handshake with the shared multiplier
module asmd_mult_arbiter
    import asmd_pkg::*;
#(
    parameter int word_length  = DEF_WORD_LENGTH,
    parameter int num_req      = DEF_NUM_REQ,
    parameter int busy_timeout = DEF_BUSY_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [num_req-1:0]             req_valid,
    input  logic [num_req*word_length-1:0] req_word0,
    input  logic [num_req*word_length-1:0] req_word1,
    output logic [num_req-1:0]             req_grant,
    output logic [num_req-1:0]             resp_valid,
    output logic [2*word_length-1:0]       resp_product,
    output logic                           resp_err,
    output logic                           busy,
    output logic                           mult_start,
    output logic [word_length-1:0]         mult_word0,
    output logic [word_length-1:0]         mult_word1,
    input  logic                           mult_ready,
    input  logic [2*word_length-1:0]       mult_product
);

    localparam int IDW = idxWidth(num_req);
    localparam int CW  = $clog2(busy_timeout + 1);

    state_t                   state_q, state_d;
    logic [IDW-1:0]           id_q, id_d;
    logic [IDW-1:0]           lastGrant_q, lastGrant_d;
    logic [word_length-1:0]   opA_q, opA_d;
    logic [word_length-1:0]   opB_q, opB_d;
    logic [2*word_length-1:0] product_q, product_d;
    logic                     err_q, err_d;
    logic [CW-1:0]            count_q, count_d;

    logic [num_req-1:0]       grantOneHot;
    logic [IDW-1:0]           winnerIdx;
    logic [word_length-1:0]   winA, winB;

    rr_arbiter #(.num_req(num_req)) u_rr (
        .req        (req_valid),
        .last_grant (lastGrant_q),
        .grant      (grantOneHot)
    );

    // Turn the one-hot winner into an index and pick out its operand slices
    always_comb begin
        winnerIdx = '0;
        winA      = '0;
        winB      = '0;
        for (int i = 0; i < num_req; i++) begin
            if (grantOneHot[i]) begin
                winnerIdx = IDW'(i);
                winA      = req_word0[i*word_length +: word_length];
                winB      = req_word1[i*word_length +: word_length];
            end
        end
    end

    // State and job registers; reset lands in IDLE with requester 0 next
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            id_q        <= '0;
            lastGrant_q <= IDW'(num_req - 1);
            opA_q       <= '0;
            opB_q       <= '0;
            product_q   <= '0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            lastGrant_q <= lastGrant_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            product_q   <= product_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    // Next-state logic. A job is accepted only when the multiplier is idle;
    // WAIT_BUSY waits for the multiplier to acknowledge the start by dropping
    // ready and gives up after busy_timeout cycles, WAIT_DONE waits without
    // limit for the result.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        lastGrant_d = lastGrant_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        product_d   = product_q;
        err_d       = err_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (mult_ready && (req_valid != '0)) begin
                    id_d        = winnerIdx;
                    lastGrant_d = winnerIdx;
                    opA_d       = winA;
                    opB_d       = winB;
                    err_d       = 1'b0;
                    count_d     = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                count_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!mult_ready) begin
                    state_d = WAIT_DONE;
                end else if (count_q == CW'(busy_timeout - 1)) begin
                    err_d     = 1'b1;
                    product_d = '0;
                    state_d   = RESP;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (mult_ready) begin
                    product_d = mult_product;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant and response pulses are decoded from the state so they last
    // exactly one cycle and vanish immediately on reset
    always_comb begin
        req_grant  = '0;
        resp_valid = '0;
        if (state_q == ISSUE) begin
            req_grant[id_q] = 1'b1;
        end
        if (state_q == RESP) begin
            resp_valid[id_q] = 1'b1;
        end
    end

    assign resp_product = (state_q == RESP) ? product_q : '0;
    assign resp_err     = (state_q == RESP) && err_q;
    assign busy         = (state_q != IDLE);
    assign mult_start   = (state_q == ISSUE);
    assign mult_word0   = opA_q;
    assign mult_word1   = opB_q;

endmodule
